// File: rtl/wall_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : wall_sequencer
// Description : Game-flow controller for the wall/graphics datapath. Owns the
//               game state, steps the wall depth toward the player frame by
//               frame, counts collision pixels during the check frame, and
//               resolves each wall as pass or game over.
// Options     : WALL_SPEEDUP_EN - when defined, a runtime step register
//               starts at FRAMES_PER_STEP and shrinks by one (minimum 1)
//               after every passed wall.
// Revision    : 1.0 - initial release
// ============================================================================
module wall_sequencer #(
    parameter int MAX_WALL_DEPTH      = 75,
    parameter int GOAL_DEPTH          = 60,
    parameter int GOAL_DEPTH_DELTA    = 10,
    parameter int FRAMES_PER_STEP     = 2,
    parameter int COLLISION_THRESHOLD = 2000,
    parameter int PASS_FRAMES         = 30,
    parameter int NUM_WALLS           = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       new_frame_in,
    input  logic       pixel_valid_in,
    input  logic       is_collision_in,
    input  logic [7:0] player_depth_in,
    input  logic       start_in,
    output logic [2:0] game_state_out,
    output logic [7:0] wall_depth_out,
    output logic [2:0] wall_id_out,
    output logic [7:0] score_out,
    output logic       result_valid_out,
    output logic       result_pass_out
);

    // Frame counter is shared by APPROACH (counts to step-1) and PASS
    // (counts to PASS_FRAMES-1), so it must hold the larger of the two.
    localparam int FCW = ($clog2(PASS_FRAMES) > 4) ? $clog2(PASS_FRAMES) : 4;

    // Player-depth window, computed wide and clamped into the 8-bit range.
    localparam int WIN_LO_I = GOAL_DEPTH - GOAL_DEPTH_DELTA;
    localparam int WIN_HI_I = GOAL_DEPTH + GOAL_DEPTH_DELTA;
    localparam logic [7:0] WIN_LO = 8'((WIN_LO_I < 0)   ? 0   : WIN_LO_I);
    localparam logic [7:0] WIN_HI = 8'((WIN_HI_I > 255) ? 255 : WIN_HI_I);

    localparam logic [7:0]     MAX_D      = 8'(MAX_WALL_DEPTH);
    localparam logic [7:0]     GOAL_D     = 8'(GOAL_DEPTH);
    localparam logic [20:0]    THRESH_W   = 21'(COLLISION_THRESHOLD);
    localparam logic [FCW-1:0] PASS_LAST  = FCW'(PASS_FRAMES - 1);
    localparam logic [2:0]     WALL_LAST  = 3'(NUM_WALLS - 1);
    localparam logic [3:0]     STEP_INIT  = 4'(FRAMES_PER_STEP);

    typedef enum logic [2:0] {
        S_GAME_OVER = 3'd0,
        S_IDLE      = 3'd1,
        S_APPROACH  = 3'd2,
        S_CHECK     = 3'd3,
        S_PASS      = 3'd4
    } state_t;

    state_t          state_q;
    logic [7:0]      depth_q;
    logic [2:0]      wall_id_q;
    logic [7:0]      score_q;
    logic            result_valid_q;
    logic            result_pass_q;
    logic [FCW-1:0]  frame_cnt_q;
    logic [19:0]     coll_cnt_q;

    logic [3:0]      step_d;
    logic [FCW-1:0]  step_last_d;
    logic [7:0]      depth_dec_d;
    logic [7:0]      depth_sat_dec_d;
    logic [2:0]      wall_next_d;
    logic [7:0]      score_inc_d;
    logic            pass_d;

`ifdef WALL_SPEEDUP_EN
    logic [3:0]      step_q;
    assign step_d = step_q;
`else
    assign step_d = STEP_INIT;
`endif

    // Next-value helpers shared by the state machine below.
    always_comb begin
        step_last_d     = FCW'(step_d - 4'd1);
        depth_dec_d     = depth_q - 8'd1;
        depth_sat_dec_d = (depth_q == 8'd0) ? 8'd0 : depth_q - 8'd1;
        wall_next_d     = (wall_id_q == WALL_LAST) ? 3'd0 : wall_id_q + 3'd1;
        score_inc_d     = (score_q == 8'hFF) ? 8'hFF : score_q + 8'd1;
        pass_d          = ({1'b0, coll_cnt_q} <= THRESH_W)
                        && (player_depth_in >= WIN_LO)
                        && (player_depth_in <= WIN_HI);
    end

    // Game-flow state machine with all outputs registered.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= S_IDLE;
            depth_q        <= MAX_D;
            wall_id_q      <= 3'd0;
            score_q        <= 8'd0;
            result_valid_q <= 1'b0;
            result_pass_q  <= 1'b0;
            frame_cnt_q    <= '0;
            coll_cnt_q     <= '0;
`ifdef WALL_SPEEDUP_EN
            step_q         <= STEP_INIT;
`endif
        end else begin
            result_valid_q <= 1'b0;
            result_pass_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    depth_q <= MAX_D;
                    // A frame pulse coinciding with start is deliberately
                    // dropped so the new wall always begins at counter 0.
                    if (start_in) begin
                        score_q     <= 8'd0;
                        frame_cnt_q <= '0;
                        wall_id_q   <= 3'd0;
`ifdef WALL_SPEEDUP_EN
                        step_q      <= STEP_INIT;
`endif
                        state_q     <= S_APPROACH;
                    end
                end
                S_APPROACH: begin
                    if (new_frame_in) begin
                        if (frame_cnt_q == step_last_d) begin
                            frame_cnt_q <= '0;
                            depth_q     <= depth_dec_d;
                            if (depth_dec_d == GOAL_D) begin
                                coll_cnt_q <= '0;
                                state_q    <= S_CHECK;
                            end
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    // The closing frame pulse resolves the check; that
                    // cycle's pixel sample is intentionally excluded.
                    if (new_frame_in) begin
                        result_valid_q <= 1'b1;
                        result_pass_q  <= pass_d;
                        state_q        <= pass_d ? S_PASS : S_GAME_OVER;
`ifdef WALL_SPEEDUP_EN
                        if (pass_d && (step_q > 4'd1)) begin
                            step_q <= step_q - 4'd1;
                        end
`endif
                    end else if (pixel_valid_in && is_collision_in
                                 && (coll_cnt_q != 20'hFFFFF)) begin
                        coll_cnt_q <= coll_cnt_q + 20'd1;
                    end
                end
                S_PASS: begin
                    if (new_frame_in) begin
                        if (frame_cnt_q == PASS_LAST) begin
                            score_q     <= score_inc_d;
                            wall_id_q   <= wall_next_d;
                            depth_q     <= MAX_D;
                            frame_cnt_q <= '0;
                            state_q     <= S_APPROACH;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                            depth_q     <= depth_sat_dec_d;
                        end
                    end
                end
                S_GAME_OVER: begin
                    if (start_in) begin
                        depth_q <= MAX_D;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign game_state_out   = state_q;
    assign wall_depth_out   = depth_q;
    assign wall_id_out      = wall_id_q;
    assign score_out        = score_q;
    assign result_valid_out = result_valid_q;
    assign result_pass_out  = result_pass_q;

endmodule
`default_nettype wire

// File: tb/tb_wall_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wall_sequencer
// Description : Directed self-checking bench for wall_sequencer using the
//               reduced parameter set MAX=5 GOAL=3 DELTA=1 STEP=2 THRESH=4
//               PASS_FRAMES=2 NUM_WALLS=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wall_sequencer;

`ifdef WALL_SPEEDUP_EN
    localparam int AF_FAST = 2;   // approach frames once the step is 1
`else
    localparam int AF_FAST = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       new_frame = 1'b0;
    logic       pixel_valid = 1'b0;
    logic       is_collision = 1'b0;
    logic [7:0] player_depth = 8'd0;
    logic       start = 1'b0;
    logic [2:0] game_state;
    logic [7:0] wall_depth;
    logic [2:0] wall_id;
    logic [7:0] score;
    logic       result_valid;
    logic       result_pass;

    int checks = 0;
    int errors = 0;

    wall_sequencer #(
        .MAX_WALL_DEPTH      (5),
        .GOAL_DEPTH          (3),
        .GOAL_DEPTH_DELTA    (1),
        .FRAMES_PER_STEP     (2),
        .COLLISION_THRESHOLD (4),
        .PASS_FRAMES         (2),
        .NUM_WALLS           (2)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .new_frame_in     (new_frame),
        .pixel_valid_in   (pixel_valid),
        .is_collision_in  (is_collision),
        .player_depth_in  (player_depth),
        .start_in         (start),
        .game_state_out   (game_state),
        .wall_depth_out   (wall_depth),
        .wall_id_out      (wall_id),
        .score_out        (score),
        .result_valid_out (result_valid),
        .result_pass_out  (result_pass)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame pulse followed by one quiet cycle.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            new_frame = 1'b1;
            tick();
            new_frame = 1'b0;
            tick();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic collide(input int n);
        pixel_valid  = 1'b1;
        is_collision = 1'b1;
        for (int i = 0; i < n; i++) tick();
        pixel_valid  = 1'b0;
        is_collision = 1'b0;
        tick();
    endtask

    // Closing frame pulse; result is visible straight after this edge.
    task automatic close_check(input logic hit_on_close);
        new_frame    = 1'b1;
        pixel_valid  = hit_on_close;
        is_collision = hit_on_close;
        tick();
        new_frame    = 1'b0;
        pixel_valid  = 1'b0;
        is_collision = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("rst_state", game_state, 1);
        chk("rst_depth", wall_depth, 5);
        chk("rst_score", score, 0);
        chk("rst_rvalid", result_valid, 0);
        chk("rst_rpass", result_pass, 0);
        chk("rst_wall", wall_id, 0);

        // Clean pass
        pulse_start();
        chk("start_state", game_state, 2);
        frames(3);
        chk("appr3_state", game_state, 2);
        chk("appr3_depth", wall_depth, 4);
        frames(1);
        chk("appr4_state", game_state, 3);
        chk("appr4_depth", wall_depth, 3);
        player_depth = 8'd3;
        collide(4);
        chk("check_frozen", wall_depth, 3);
        close_check(1'b0);
        chk("p1_rvalid", result_valid, 1);
        chk("p1_rpass", result_pass, 1);
        chk("p1_state", game_state, 4);
        tick();
        chk("p1_rvalid_pulse", result_valid, 0);
        frames(1);
        chk("p1_passdepth", wall_depth, 2);
        frames(1);
        chk("p1_score", score, 1);
        chk("p1_wall", wall_id, 1);
        chk("p1_depth", wall_depth, 5);
        chk("p1_state2", game_state, 2);

        // Second wall: approach length depends on the speedup option,
        // 4+1 collisions (last on the close cycle) still passes.
        frames(AF_FAST - 1);
        chk("a2_pre_state", game_state, 2);
        frames(1);
        chk("a2_state", game_state, 3);
        player_depth = 8'd2;
        collide(4);
        close_check(1'b1);
        chk("p2_rpass", result_pass, 1);
        chk("p2_state", game_state, 4);
        frames(2);
        chk("p2_score", score, 2);
        chk("p2_wall_wrap", wall_id, 0);

        // Third wall: step stays at its minimum, upper window edge passes.
        frames(AF_FAST - 1);
        chk("a3_pre_state", game_state, 2);
        frames(1);
        chk("a3_state", game_state, 3);
        player_depth = 8'd4;
        close_check(1'b0);
        chk("p3_rpass", result_pass, 1);
        frames(2);
        chk("p3_score", score, 3);
        chk("p3_wall", wall_id, 1);

        // Collision fail
        frames(AF_FAST);
        chk("a4_state", game_state, 3);
        player_depth = 8'd3;
        collide(5);
        close_check(1'b0);
        chk("cf_rvalid", result_valid, 1);
        chk("cf_rpass", result_pass, 0);
        chk("cf_state", game_state, 0);
        frames(3);
        chk("go_depth", wall_depth, 3);
        chk("go_score", score, 3);
        chk("go_state", game_state, 0);
        pulse_start();
        chk("go_start_state", game_state, 1);
        chk("go_start_depth", wall_depth, 5);

        // Depth fail (speedup step restored by start)
        pulse_start();
        chk("df_score", score, 0);
        frames(4);
        chk("df_chk_state", game_state, 3);
        player_depth = 8'd5;
        close_check(1'b0);
        chk("df_rvalid", result_valid, 1);
        chk("df_rpass", result_pass, 0);
        chk("df_state", game_state, 0);
        pulse_start();

        // Reset mid-CHECK
        pulse_start();
        frames(4);
        chk("rm_chk_state", game_state, 3);
        collide(2);
        rst = 1'b1;
        tick();
        chk("rm_state", game_state, 1);
        chk("rm_depth", wall_depth, 5);
        chk("rm_rvalid", result_valid, 0);
        rst = 1'b0;
        tick();
        chk("rm_rvalid2", result_valid, 0);

        // start coincident with new_frame in IDLE: frame is dropped
        start = 1'b1;
        new_frame = 1'b1;
        tick();
        start = 1'b0;
        new_frame = 1'b0;
        chk("co_state", game_state, 2);
        chk("co_depth", wall_depth, 5);
        frames(3);
        chk("co_depth3", wall_depth, 4);
        chk("co_state3", game_state, 2);
        frames(1);
        chk("co_state4", game_state, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
